// File: rtl/gs_pkg.sv
// Shared types and constants for the Goldschmidt divide controller.
// Latency: none (declarations only).
// Backpressure: none.
package gs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PH_D,
        PH_N,
        DRAIN1,
        DRAIN2,
        DONE
    } state_t;

    localparam int          FRAC      = 15;
    localparam logic [15:0] Q_SAT     = 16'hFFFF;
    localparam logic [15:0] NORM_MASK = 16'hC000;
    localparam logic [15:0] NORM_VAL  = 16'h4000;

    // A usable divisor lies in [0.5,1): top two bits must read 2'b01.
    function automatic logic is_norm(input logic [15:0] d);
        return (d & NORM_MASK) == NORM_VAL;
    endfunction

endpackage

// File: rtl/gs_rne.sv
// Rounds a Q2.30 datapath product to Q1.15, nearest-even, saturating.
// Latency: combinational.
// Backpressure: none.
module gs_rne #(
    parameter int W = 16
) (
    input  logic [2*W-1:0] x,
    output logic [W-1:0]   y
);

    logic [W-1:0] base;
    logic         guard;
    logic         sticky;
    logic         inc;
    logic [W:0]   sum;

    always_comb begin
        base   = x[2*W-2:W-1];
        guard  = x[W-2];
        sticky = |x[W-3:0];
        inc    = guard & (sticky | base[0]);
        sum    = {1'b0, base} + {{W{1'b0}}, inc};
        // Integer bit set or carry out of the increment both mean >= 2.0.
        y      = (x[2*W-1] | sum[W]) ? {W{1'b1}} : sum[W-1:0];
    end

endmodule

// File: rtl/gs_div_ctrl.sv
// Sequences one Goldschmidt divide: N/D select, K source, operand feedback, quotient capture.
// Latency: done 2*ITERS+3 cycles after accept; 1 cycle for an unnormalized divisor.
// Backpressure: single request in flight; start ignored unless idle, no queueing.
module gs_div_ctrl
    import gs_pkg::*;
#(
    parameter int ITERS = 3,
    parameter int W     = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   n_in,
    input  logic [W-1:0]   d_in,
    input  logic [W-1:0]   ia_in,
    input  logic [2*W-1:0] result,
    output logic           nd_select,
    output logic           k_select,
    output logic [W-1:0]   n_out,
    output logic [W-1:0]   d_out,
    output logic [W-1:0]   ia_out,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W-1:0]   q
);

    localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

    state_t       state;
    logic [2:0]   iter;
    logic [W-1:0] n_reg;
    logic [W-1:0] d_reg;
    logic [W-1:0] ia_reg;
    logic [W-1:0] rnd_q;

    gs_rne #(.W(W)) u_rne (
        .x (result),
        .y (rnd_q)
    );

    assign ia_out = ia_reg;

    // From the second iteration on, the product just leaving the datapath is the
    // next operand, so it is forwarded in the same cycle it appears.
    always_comb begin
        n_out = n_reg;
        d_out = d_reg;
        if (state == PH_D && iter != 3'd0) d_out = rnd_q;
        if (state == PH_N && iter != 3'd0) n_out = rnd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            iter      <= 3'd0;
            n_reg     <= '0;
            d_reg     <= '0;
            ia_reg    <= '0;
            nd_select <= 1'b1;
            k_select  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg  <= n_in;
                        d_reg  <= d_in;
                        ia_reg <= ia_in;
                        iter   <= 3'd0;
                        if (is_norm(d_in)) begin
                            state     <= PH_D;
                            nd_select <= 1'b0;
                            k_select  <= 1'b1;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                        end else begin
                            state <= DONE;
                            err   <= 1'b1;
                            q     <= Q_SAT;
                            done  <= 1'b1;
                        end
                    end
                end
                PH_D: begin
                    if (iter != 3'd0) d_reg <= rnd_q;
                    state     <= PH_N;
                    nd_select <= 1'b1;
                    k_select  <= 1'b0;
                end
                PH_N: begin
                    if (iter != 3'd0) n_reg <= rnd_q;
                    if (iter == LAST_ITER) begin
                        state <= DRAIN1;
                    end else begin
                        state     <= PH_D;
                        iter      <= iter + 3'd1;
                        nd_select <= 1'b0;
                    end
                end
                DRAIN1: state <= DRAIN2;
                DRAIN2: begin
                    // Product register now holds N_last*K_last.
                    q     <= rnd_q;
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gs_div_ctrl.sv
// Bench for gs_div_ctrl with a two-stage multiply datapath stub and an algorithmic quotient model.
module tb_gs_div_ctrl;

    localparam int ITERS = 3;
    localparam int W     = 16;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] n_in, d_in, ia_in;
    logic [31:0] result;
    logic        nd_select, k_select, busy, done, err;
    logic [15:0] n_out, d_out, ia_out, q;

    logic [31:0] p1;
    logic [15:0] kreg, kc;
    int          checks = 0;
    int          passes = 0;
    int          dn;

    gs_div_ctrl #(.ITERS(ITERS), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_in      (n_in),
        .d_in      (d_in),
        .ia_in     (ia_in),
        .result    (result),
        .nd_select (nd_select),
        .k_select  (k_select),
        .n_out     (n_out),
        .d_out     (d_out),
        .ia_out    (ia_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .q         (q)
    );

    always #5 clk = ~clk;

    // Round to nearest even by comparing the discarded remainder with one half LSB.
    function automatic logic [15:0] rnd(input logic [31:0] x);
        int unsigned b;
        int unsigned rem;
        b   = x >> 15;
        rem = x & 32'h7FFF;
        if (rem > 32'h4000 || (rem == 32'h4000 && b[0])) b = b + 1;
        return (b > 32'd65535) ? 16'hFFFF : 16'(b);
    endfunction

    // Datapath stub: K register loads on D cycles, product takes two cycles.
    always_comb kc = k_select ? ia_out : 16'(32'h10000 - 32'(rnd(result)));

    always @(posedge clk) begin
        if (reset) begin
            p1     <= '0;
            result <= '0;
            kreg   <= '0;
        end else begin
            if (!nd_select) kreg <= kc;
            p1     <= 32'(nd_select ? n_out : d_out) * 32'(nd_select ? kreg : kc);
            result <= p1;
        end
    end

    task automatic ref_model(input logic [15:0] n, d, ia,
                             output logic [15:0] q_e, output logic err_e);
        logic [15:0] nn, dd, k;
        if (d < 16'h4000 || d >= 16'h8000) begin
            q_e   = 16'hFFFF;
            err_e = 1'b1;
        end else begin
            nn = n;
            dd = d;
            k  = ia;
            for (int i = 0; i < ITERS; i++) begin
                nn = rnd(32'(nn) * 32'(k));
                dd = rnd(32'(dd) * 32'(k));
                k  = 16'(32'h10000 - 32'(dd));
            end
            q_e   = nn;
            err_e = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_div(input logic [15:0] n, d, ia, input bit hold);
        logic [15:0] exp_q;
        logic        exp_err;
        int          exp_lat, lat;
        ref_model(n, d, ia, exp_q, exp_err);
        exp_lat = exp_err ? 1 : 2 * ITERS + 3;
        @(negedge clk);
        start = 1'b1; n_in = n; d_in = d; ia_in = ia;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            start = hold;
            n_in  = 16'($urandom); d_in = 16'($urandom); ia_in = 16'($urandom);
            if (exp_err && c == 1) check("err_nd_select", nd_select, 1);
            if (!exp_err && c < exp_lat) begin
                check("nd_select", nd_select, (c <= 2 * ITERS && c % 2 == 1) ? 0 : 1);
                check("k_select", k_select, (c == 1) ? 1 : 0);
                check("busy", busy, 1);
                if (c >= 3 && c <= 2 * ITERS) begin
                    if (c % 2 == 1) check("d_bypass", d_out, rnd(result));
                    else            check("n_bypass", n_out, rnd(result));
                end
            end
            if (done) begin
                lat   = c;
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("q", q, exp_q);
        check("err", err, exp_err);
        repeat (3) begin
            @(negedge clk);
            check("post_done", done, 0);
            check("post_busy", busy, 0);
            check("q_held", q, exp_q);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rn, rd, ria;
        reset = 1'b1; start = 1'b0; n_in = '0; d_in = '0; ia_in = '0;
        repeat (2) @(negedge clk);
        check("rst_nd_select", nd_select, 1);
        check("rst_k_select", k_select, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_q", q, 0);
        check("rst_n_out", n_out, 0);
        check("rst_d_out", d_out, 0);
        check("rst_ia_out", ia_out, 0);
        reset = 1'b0;

        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("idle_no_done", dn, 0);
        check("idle_busy", busy, 0);

        do_div(16'h4000, 16'h6000, 16'hAAAB, 1'b0);
        check("q_near_5555", (q >= 16'h5554 && q <= 16'h5556), 1);

        do_div(16'h4000, 16'h3000, 16'hAAAB, 1'b0);
        do_div(16'h4000, 16'h6000, 16'hAAAB, 1'b0);
        do_div(16'h7FFF, 16'h4000, 16'hFFFF, 1'b1);
        check("no_wrap", (q >= 16'hF000), 1);
        do_div(16'hFFFF, 16'h4000, 16'hFFFF, 1'b0);
        check("q_saturated", q, 16'hFFFF);

        // Abort a divide with reset in its fourth cycle.
        @(negedge clk);
        start = 1'b1; n_in = 16'h2000; d_in = 16'h5000; ia_in = 16'hCCCD;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_nd_select", nd_select, 1);
        check("abort_n_out", n_out, 0);
        check("abort_d_out", d_out, 0);
        check("abort_ia_out", ia_out, 0);
        check("abort_q", q, 0);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        do_div(16'h2000, 16'h5000, 16'hCCCD, 1'b0);

        for (int t = 0; t < 40; t++) begin
            rn = 16'($urandom_range(0, 16'h7FFF));
            if ($urandom_range(0, 9) == 0)
                rd = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h3FFF))
                                                 : 16'($urandom_range(16'h8000, 16'hFFFF));
            else
                rd = 16'($urandom_range(16'h4000, 16'h7FFF));
            if (t % 2 == 0 && rd >= 16'h4000)
                ria = (32'h4000_0000 / 32'(rd) > 32'hFFFF) ? 16'hFFFF
                                                           : 16'(32'h4000_0000 / 32'(rd));
            else
                ria = 16'($urandom);
            do_div(rn, rd, ria, t % 3 == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gs_div_ctrl.md
Name: gs_div_ctrl

Overview:
- Sequencing controller for the two-stage Goldschmidt divide datapath (N/D select register, K register, CSAM product register).
- Accepts one divide request and drives the per-cycle select controls (nd_select, k_select).
- Feeds the iterated N_i/D_i operands back into the datapath and captures the rounded final quotient.
- Owns the start/busy/done handshake, so requesters never touch datapath selects directly.

Parameters:
- ITERS, 3: Goldschmidt iterations, legal range 1..7.
- W, 16: operand width. Q1.15 unsigned; datapath product is 2W bits, Q2.30.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only while busy=0
- n_in  in  W  numerator, Q1.15, range [0,1)
- d_in  in  W  divisor, Q1.15, must be normalized to [0.5,1) (d_in[15:14]=2'b01)
- ia_in  in  W  initial approximation of 1/D, Q1.15
- result  in  2W  datapath product register output
- nd_select  out  1  datapath select: 1 = N operand, 0 = D operand. Also loads the K register when 0.
- k_select  out  1  datapath K source: 1 = IA, 0 = derived from rounded product
- n_out  out  W  datapath N operand
- d_out  out  W  datapath D operand
- ia_out  out  W  latched IA
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; q and err valid
- err  out  1  sticky until next accept; divisor not normalized
- q  out  W  quotient, Q1.15; held until next accept

Behaviour:
- Reset: state IDLE; nd_select=1, k_select=0, busy=0, done=0, err=0; q, n_out, d_out, ia_out = 0; iteration counter = 0.
- Reset mid-operation aborts immediately. No done is issued.
- Accept: in IDLE with start=1, latch n_in, d_in, ia_in and clear err.
  - If d_in[15:14]!=2'b01: next cycle is DONE with q=16'hFFFF and err=1. No datapath activity.
- States: IDLE, PH_D, PH_N, DRAIN1, DRAIN2, DONE.
  - Accept at cycle 0.
  - Iteration i runs PH_D at cycle 2i+1 and PH_N at cycle 2i+2, for i=0..ITERS-1.
  - PH_D: nd_select=0. k_select=1 when i=0, else 0.
  - PH_N: nd_select=1, k_select=0.
  - DRAIN1 and DRAIN2: nd_select=1 (K held).
  - DONE: done=1 for one cycle, then return to IDLE.
- Operand bypass:
  - i=0: d_out and n_out are the latched d_in and n_in.
  - i>0: in PH_D, d_out = rnd(result), which equals D_{i-1}*K_{i-1}. In PH_N, n_out = rnd(result).
  - The bypassed values are also registered into d_reg/n_reg. n_out/d_out hold the registered values in all other states.
- Quotient capture: at DRAIN2, result = N_last*K_last, and q <= rnd(result).
- Latency: done asserts 2*ITERS+3 cycles after accept (9 for ITERS=3).
- rnd(x), round-to-nearest-even to Q1.15:
  - base = x[30:15], guard = x[14], sticky = |x[13:0].
  - Increment when guard & (sticky | base[0]).
  - Saturate to 16'hFFFF if x[31]=1 or the increment overflows.
- start while busy, or during DONE, is ignored. No queueing.
- start in the same cycle that done drops back to IDLE: accepted on that IDLE cycle only.

Decomposition:
- Shared package gs_pkg holds:
  - state enum typedef;
  - Q-format constants (FRAC=15, Q_SAT=16'hFFFF);
  - the normalization check mask.
- One sub-module, gs_rne: combinational 2W->W rounder implementing rnd(). Instantiated once; its output feeds the bypass muxes and the q capture.

Test Plan:
- Reset then idle: nd_select=1, busy=0, q=0. Hold start=0 for 20 cycles -> no done.
- N=0x4000, D=0x6000, IA=0xAAAB, ITERS=3 -> done at cycle 9, q within 1 LSB of 0x5555, err=0.
- Select sequence check for ITERS=3:
  - nd_select = 0,1,0,1,0,1,1,1 on cycles 1..8;
  - k_select=1 only on cycle 1;
  - n_out/d_out equal rnd(result) on cycles 3..6.
- D=0x3000 (unnormalized) -> done at cycle 1, err=1, q=0xFFFF, nd_select stays 1.
- N=0x7FFF, D=0x4000, IA=0xFFFF -> q saturates to 0xFFFF without wrap. Second start asserted while busy is ignored.
- Assert reset at cycle 4 of a divide -> next cycle IDLE, all outputs 0. A new request then completes with correct q and latency.
